// File: rtl/ahb_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ahb_arb2                                                        |
// | Brief    : Two-master AHB-Lite arbiter sharing one slave path. Master 0 is |
// |            the CPU BIU, master 1 the smart_run DMA/debug master. Grant     |
// |            moves only when the owner is IDLE and the slave is ready, so    |
// |            bursts and pipelined transfers are never split.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ahb_arb2 #(
    parameter int unsigned PARK_MST = 0,
    parameter int unsigned WAIT_W   = 16
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_b,
    // master 0 (CPU BIU)
    input  logic [31:0]       m0_haddr,
    input  logic [1:0]        m0_htrans,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [2:0]        m0_hburst,
    input  logic [3:0]        m0_hprot,
    input  logic [31:0]       m0_hwdata,
    output logic              m0_hready,
    output logic [1:0]        m0_hresp,
    // master 1 (smart_run DMA/debug)
    input  logic [31:0]       m1_haddr,
    input  logic [1:0]        m1_htrans,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [2:0]        m1_hburst,
    input  logic [3:0]        m1_hprot,
    input  logic [31:0]       m1_hwdata,
    output logic              m1_hready,
    output logic [1:0]        m1_hresp,
    // read data broadcast to both masters
    output logic [31:0]       arb_hrdata,
    // shared slave path
    output logic [31:0]       arb_pad_haddr,
    output logic [1:0]        arb_pad_htrans,
    output logic              arb_pad_hwrite,
    output logic [2:0]        arb_pad_hsize,
    output logic [2:0]        arb_pad_hburst,
    output logic [3:0]        arb_pad_hprot,
    output logic [31:0]       arb_pad_hwdata,
    input  logic              pad_arb_hready,
    input  logic [1:0]        pad_arb_hresp,
    input  logic [31:0]       pad_arb_hrdata,
    // status
    output logic              arb_owner,
    output logic [WAIT_W-1:0] m0_wait_cnt,
    output logic [WAIT_W-1:0] m1_wait_cnt
);

    localparam logic              c_PARK     = PARK_MST[0];
    localparam logic [1:0]        c_IDLE     = 2'b00;
    localparam logic [1:0]        c_OKAY     = 2'b00;
    localparam logic [WAIT_W-1:0] c_CNT_MAX  = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] c_CNT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] c_CNT_ZERO = {WAIT_W{1'b0}};

    // per-master views, indexed by master number
    logic [1:0][1:0]        w_htrans;
    logic [1:0][31:0]       w_hwdata;
    logic [1:0]             w_req;
    logic [1:0]             w_hready;
    logic [1:0][1:0]        w_hresp;
    logic [1:0][WAIT_W-1:0] r_wait_cnt;

    // arbitration state
    logic                   r_addr_owner;
    logic                   r_dph_owner;
    logic                   r_dph_vld;
    logic [1:0]             w_own_htrans;
    logic                   w_switch_ok;
    logic                   w_other_req;
    logic                   w_owner_nxt;

    assign w_htrans = {m1_htrans, m0_htrans};
    assign w_hwdata = {m1_hwdata, m0_hwdata};
    assign w_req    = {m1_htrans[1], m0_htrans[1]};

    // Owner transfer type and the safe-boundary test. BUSY keeps the grant
    // because a burst is still in progress.
    assign w_own_htrans = r_addr_owner ? m1_htrans : m0_htrans;
    assign w_switch_ok  = pad_arb_hready && (w_own_htrans == c_IDLE);
    assign w_other_req  = w_req[~r_addr_owner];

    // Grant decision for the next cycle: hand over to a waiting master,
    // otherwise park, otherwise keep the current owner.
    always_comb begin
        w_owner_nxt = r_addr_owner;
        if (w_switch_ok) begin
            if (w_other_req) begin
                w_owner_nxt = ~r_addr_owner;
            end else if (w_req == 2'b00) begin
                w_owner_nxt = c_PARK;
            end
        end
    end

    // Address-phase owner register.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_b) begin
            r_addr_owner <= c_PARK;
        end else begin
            r_addr_owner <= w_owner_nxt;
        end
    end

    // Data-phase tracking advances only when the slave accepts the address
    // phase, so it always names the master whose transfer is in data phase.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_b) begin
            r_dph_owner <= 1'b0;
            r_dph_vld   <= 1'b0;
        end else if (pad_arb_hready) begin
            r_dph_owner <= r_addr_owner;
            r_dph_vld   <= w_own_htrans[1];
        end
    end

    // Address-phase mux onto the shared path.
    always_comb begin
        if (r_addr_owner) begin
            arb_pad_haddr  = m1_haddr;
            arb_pad_htrans = m1_htrans;
            arb_pad_hwrite = m1_hwrite;
            arb_pad_hsize  = m1_hsize;
            arb_pad_hburst = m1_hburst;
            arb_pad_hprot  = m1_hprot;
        end else begin
            arb_pad_haddr  = m0_haddr;
            arb_pad_htrans = m0_htrans;
            arb_pad_hwrite = m0_hwrite;
            arb_pad_hsize  = m0_hsize;
            arb_pad_hburst = m0_hburst;
            arb_pad_hprot  = m0_hprot;
        end
    end

    // Write data follows the data-phase owner, one cycle behind the address.
    assign arb_pad_hwdata = w_hwdata[r_dph_owner];
    assign arb_hrdata     = pad_arb_hrdata;
    assign arb_owner      = r_addr_owner;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mst
            localparam logic c_IDX = 1'(gi);

            // Owner sees the slave ready; a requesting non-owner is stalled
            // and must hold its address, an idle non-owner sees ready.
            assign w_hready[gi] = (r_addr_owner == c_IDX) ? pad_arb_hready
                                                          : ~w_htrans[gi][1];

            // Responses reach only the master owning the live data phase.
            assign w_hresp[gi]  = (r_dph_vld && (r_dph_owner == c_IDX))
                                  ? pad_arb_hresp : c_OKAY;

            // Stall counter: clears on the grant, otherwise counts saturating
            // while this master waits for the bus.
            always_ff @(posedge cpu_clk) begin
                if (!cpu_rst_b) begin
                    r_wait_cnt[gi] <= c_CNT_ZERO;
                end else if ((w_owner_nxt == c_IDX) && (r_addr_owner != c_IDX)) begin
                    r_wait_cnt[gi] <= c_CNT_ZERO;
                end else if ((r_addr_owner != c_IDX) && w_req[gi] &&
                             (r_wait_cnt[gi] != c_CNT_MAX)) begin
                    r_wait_cnt[gi] <= r_wait_cnt[gi] + c_CNT_ONE;
                end
            end
        end
    endgenerate

    assign m0_hready   = w_hready[0];
    assign m1_hready   = w_hready[1];
    assign m0_hresp    = w_hresp[0];
    assign m1_hresp    = w_hresp[1];
    assign m0_wait_cnt = r_wait_cnt[0];
    assign m1_wait_cnt = r_wait_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_ahb_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ahb_arb2                                                     |
// | Brief    : Directed self-checking bench for the two-master AHB arbiter.    |
// |            Inputs change on the falling edge; outputs are sampled 1 ns     |
// |            later, well away from the rising edge.                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ahb_arb2;

    localparam int unsigned c_WAIT_W = 16;

    logic                cpu_clk;
    logic                cpu_rst_b;
    logic [31:0]         m0_haddr, m1_haddr;
    logic [1:0]          m0_htrans, m1_htrans;
    logic                m0_hwrite, m1_hwrite;
    logic [2:0]          m0_hsize, m1_hsize;
    logic [2:0]          m0_hburst, m1_hburst;
    logic [3:0]          m0_hprot, m1_hprot;
    logic [31:0]         m0_hwdata, m1_hwdata;
    logic                m0_hready, m1_hready;
    logic [1:0]          m0_hresp, m1_hresp;
    logic [31:0]         arb_hrdata;
    logic [31:0]         arb_pad_haddr;
    logic [1:0]          arb_pad_htrans;
    logic                arb_pad_hwrite;
    logic [2:0]          arb_pad_hsize;
    logic [2:0]          arb_pad_hburst;
    logic [3:0]          arb_pad_hprot;
    logic [31:0]         arb_pad_hwdata;
    logic                pad_arb_hready;
    logic [1:0]          pad_arb_hresp;
    logic [31:0]         pad_arb_hrdata;
    logic                arb_owner;
    logic [c_WAIT_W-1:0] m0_wait_cnt, m1_wait_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    ahb_arb2 #(.PARK_MST(0), .WAIT_W(c_WAIT_W)) u_dut (
        .cpu_clk        (cpu_clk),
        .cpu_rst_b      (cpu_rst_b),
        .m0_haddr       (m0_haddr),
        .m0_htrans      (m0_htrans),
        .m0_hwrite      (m0_hwrite),
        .m0_hsize       (m0_hsize),
        .m0_hburst      (m0_hburst),
        .m0_hprot       (m0_hprot),
        .m0_hwdata      (m0_hwdata),
        .m0_hready      (m0_hready),
        .m0_hresp       (m0_hresp),
        .m1_haddr       (m1_haddr),
        .m1_htrans      (m1_htrans),
        .m1_hwrite      (m1_hwrite),
        .m1_hsize       (m1_hsize),
        .m1_hburst      (m1_hburst),
        .m1_hprot       (m1_hprot),
        .m1_hwdata      (m1_hwdata),
        .m1_hready      (m1_hready),
        .m1_hresp       (m1_hresp),
        .arb_hrdata     (arb_hrdata),
        .arb_pad_haddr  (arb_pad_haddr),
        .arb_pad_htrans (arb_pad_htrans),
        .arb_pad_hwrite (arb_pad_hwrite),
        .arb_pad_hsize  (arb_pad_hsize),
        .arb_pad_hburst (arb_pad_hburst),
        .arb_pad_hprot  (arb_pad_hprot),
        .arb_pad_hwdata (arb_pad_hwdata),
        .pad_arb_hready (pad_arb_hready),
        .pad_arb_hresp  (pad_arb_hresp),
        .pad_arb_hrdata (pad_arb_hrdata),
        .arb_owner      (arb_owner),
        .m0_wait_cnt    (m0_wait_cnt),
        .m1_wait_cnt    (m1_wait_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance to the next falling edge (one rising edge passes in between)
    task automatic nxt();
        @(negedge cpu_clk);
    endtask

    initial begin
        cpu_rst_b      = 1'b0;
        m0_haddr = 32'h0; m0_htrans = 2'b00; m0_hwrite = 1'b0; m0_hsize = 3'd2;
        m0_hburst = 3'd0; m0_hprot = 4'h3; m0_hwdata = 32'h0;
        m1_haddr = 32'h0; m1_htrans = 2'b00; m1_hwrite = 1'b0; m1_hsize = 3'd2;
        m1_hburst = 3'd0; m1_hprot = 4'h1; m1_hwdata = 32'h0;
        pad_arb_hready = 1'b1;
        pad_arb_hresp  = 2'b00;
        pad_arb_hrdata = 32'hCAFE_F00D;

        // ---------------- reset state ----------------
        nxt(); nxt();
        cpu_rst_b = 1'b1;
        #1;
        chk("rst_owner",   32'(arb_owner),      32'd0);
        chk("rst_htrans",  32'(arb_pad_htrans), 32'd0);
        chk("rst_m0_rdy",  32'(m0_hready),      32'd1);
        chk("rst_m1_rdy",  32'(m1_hready),      32'd1);
        chk("rst_m0_cnt",  32'(m0_wait_cnt),    32'd0);
        chk("rst_m1_cnt",  32'(m1_wait_cnt),    32'd0);
        chk("hrdata_bc",   arb_hrdata,          32'hCAFE_F00D);

        // ---------------- single m0 write ----------------
        nxt();
        m0_htrans = 2'b10; m0_haddr = 32'h2000_0000; m0_hwrite = 1'b1;
        #1;
        chk("wr_addr",     arb_pad_haddr,       32'h2000_0000);
        chk("wr_hwrite",   32'(arb_pad_hwrite), 32'd1);
        chk("wr_m1_rdy",   32'(m1_hready),      32'd1);
        nxt();
        m0_htrans = 2'b00; m0_hwrite = 1'b0; m0_hwdata = 32'hA5A5_A5A5;
        pad_arb_hresp = 2'b01;
        #1;
        chk("wr_hwdata",   arb_pad_hwdata,      32'hA5A5_A5A5);
        chk("wr_m0_resp",  32'(m0_hresp),       32'd1);
        chk("wr_m1_resp",  32'(m1_hresp),       32'd0);
        nxt();
        pad_arb_hresp = 2'b00;

        // ---------------- m0 WRAP4 while m1 waits ----------------
        m0_htrans = 2'b10; m0_haddr = 32'h1000_0008; m0_hburst = 3'b010;
        m1_htrans = 2'b10; m1_haddr = 32'h6000_0010;
        #1;
        chk("b_m1_rdy0",   32'(m1_hready),      32'd0);
        chk("b_owner0",    32'(arb_owner),      32'd0);
        nxt(); m0_htrans = 2'b11; m0_haddr = 32'h1000_000C; #1;
        chk("b_m1_rdy1",   32'(m1_hready),      32'd0);
        nxt(); m0_htrans = 2'b11; m0_haddr = 32'h1000_0000; #1;
        chk("b_m1_rdy2",   32'(m1_hready),      32'd0);
        chk("b_owner2",    32'(arb_owner),      32'd0);
        nxt(); m0_htrans = 2'b11; m0_haddr = 32'h1000_0004; #1;
        chk("b_m1_rdy3",   32'(m1_hready),      32'd0);
        nxt(); m0_htrans = 2'b00; m0_hburst = 3'b000; #1;
        chk("b_m1_cnt4",   32'(m1_wait_cnt),    32'd4);
        chk("b_owner_idl", 32'(arb_owner),      32'd0);
        nxt(); #1;
        chk("b_owner1",    32'(arb_owner),      32'd1);
        chk("b_m1_addr",   arb_pad_haddr,       32'h6000_0010);
        chk("b_m1_cnt0",   32'(m1_wait_cnt),    32'd0);
        chk("b_m1_rdy",    32'(m1_hready),      32'd1);

        // ---------------- ERROR on m1 data phase, then park ----------------
        nxt();
        m1_htrans = 2'b00; pad_arb_hready = 1'b0; pad_arb_hresp = 2'b01;
        #1;
        chk("e_m1_resp1",  32'(m1_hresp),       32'd1);
        chk("e_m0_resp1",  32'(m0_hresp),       32'd0);
        nxt();
        pad_arb_hready = 1'b1;
        #1;
        chk("e_m1_resp2",  32'(m1_hresp),       32'd1);
        chk("e_m0_resp2",  32'(m0_hresp),       32'd0);
        chk("e_owner_hld", 32'(arb_owner),      32'd1);
        nxt(); #1;
        chk("e_park",      32'(arb_owner),      32'd0);
        chk("e_m1_resp3",  32'(m1_hresp),       32'd0);
        pad_arb_hresp = 2'b00;

        // ---------------- handover blocked by slave wait states ----------------
        nxt();
        m1_htrans = 2'b10; m1_haddr = 32'h6000_0020; pad_arb_hready = 1'b0;
        pad_arb_hresp = 2'b01;
        #1;
        chk("w_htrans0",   32'(arb_pad_htrans), 32'd0);
        chk("w_m1_rdy",    32'(m1_hready),      32'd0);
        for (int k = 1; k <= 2; k++) begin
            nxt(); #1;
            chk("w_owner_hld", 32'(arb_owner),  32'd0);
            chk("w_m0_resp",   32'(m0_hresp),   32'd0);
        end
        nxt(); pad_arb_hready = 1'b1; pad_arb_hresp = 2'b00; #1;
        chk("w_owner_rdy", 32'(arb_owner),      32'd0);
        chk("w_m1_cnt3",   32'(m1_wait_cnt),    32'd3);
        nxt(); #1;
        chk("w_owner1",    32'(arb_owner),      32'd1);
        chk("w_m1_addr",   arb_pad_haddr,       32'h6000_0020);
        chk("w_m1_cnt0",   32'(m1_wait_cnt),    32'd0);

        // ---------------- m1 starved: counter saturation ----------------
        nxt();
        m1_htrans = 2'b00; m0_htrans = 2'b10; m0_haddr = 32'h1000_0000;
        nxt();
        m1_htrans = 2'b10; m1_haddr = 32'h6000_0030;
        #1;
        chk("s_owner0",    32'(arb_owner),      32'd0);
        chk("s_addr",      arb_pad_haddr,       32'h1000_0000);
        repeat (10) nxt();
        #1;
        chk("s_cnt10",     32'(m1_wait_cnt),    32'd10);
        repeat (65525) nxt();
        #1;
        chk("s_cnt_max",   32'(m1_wait_cnt),    32'h0000_FFFF);
        repeat (5) nxt();
        #1;
        chk("s_cnt_nowrap", 32'(m1_wait_cnt),   32'h0000_FFFF);
        chk("s_m0_cnt",    32'(m0_wait_cnt),    32'd0);

        // ---------------- reset mid-transfer ----------------
        nxt();
        cpu_rst_b = 1'b0;
        pad_arb_hresp = 2'b01;
        nxt();
        cpu_rst_b = 1'b1;
        m0_htrans = 2'b00;
        m1_htrans = 2'b00;
        #1;
        chk("r_m1_cnt",    32'(m1_wait_cnt),    32'd0);
        chk("r_m0_cnt",    32'(m0_wait_cnt),    32'd0);
        chk("r_owner",     32'(arb_owner),      32'd0);
        chk("r_m0_resp",   32'(m0_hresp),       32'd0);
        chk("r_m1_resp",   32'(m1_hresp),       32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
